// File: rtl/char_ram_writer.sv
// Write-side controller for the character RAM: turns an ASCII byte stream into
// port-A writes, tracks the text cursor, and sweeps the screen with spaces on clear.
module char_ram_writer #(
  parameter int COLS   = 100,
  parameter int ROWS   = 100,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clear_req,
  output logic              busy,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dia,
  output logic [6:0]        cur_col,
  output logic [6:0]        cur_row
);

  localparam int TOTAL = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] lin, lin_next;     // linear address of the cursor cell
  logic [ADDR_W-1:0] cnt, cnt_next;     // next address the sweep will write
  logic [6:0]        col_next, row_next;
  logic              wea_next, busy_next;
  logic [ADDR_W-1:0] addra_next;
  logic [7:0]        dia_next;
  logic              accept, start_clear, col_last, row_last;
  logic [6:0]        row_inc;

  assign char_ready  = (state == S_IDLE) & ~clear_req;
  assign accept      = char_valid & char_ready;
  assign start_clear = (state == S_IDLE) & (clear_req | (accept & (char_data == 8'h0C)));
  assign col_last    = (cur_col == 7'(COLS - 1));
  assign row_last    = (cur_row == 7'(ROWS - 1));
  assign row_inc     = row_last ? 7'd0 : cur_row + 7'd1;

  always_comb begin
    state_next = state;
    col_next   = cur_col;
    row_next   = cur_row;
    lin_next   = lin;
    cnt_next   = cnt;
    wea_next   = 1'b0;
    addra_next = addra;
    dia_next   = dia;
    busy_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_clear) begin
          wea_next   = 1'b1;
          addra_next = ZERO_ADDR;
          dia_next   = 8'h20;
          col_next   = 7'd0;
          row_next   = 7'd0;
          lin_next   = ZERO_ADDR;
          cnt_next   = ADDR_W'(1);
          // a one-cell screen finishes with the entry write itself
          if (LAST_ADDR != ZERO_ADDR) begin
            state_next = S_CLEAR;
            busy_next  = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else if (accept) begin
          if ((char_data >= 8'h20) && (char_data <= 8'h7E)) begin
            wea_next   = 1'b1;
            addra_next = lin;
            dia_next   = char_data;
            if (col_last) begin
              col_next = 7'd0;
              row_next = row_inc;
              lin_next = row_last ? ZERO_ADDR : lin + ADDR_W'(1);
            end else begin
              col_next = cur_col + 7'd1;
              lin_next = lin + ADDR_W'(1);
            end
          end else begin
            case (char_data)
              8'h0A: begin
                col_next = 7'd0;
                row_next = row_inc;
                lin_next = row_last ? ZERO_ADDR : lin - ADDR_W'(cur_col) + ADDR_W'(COLS);
              end
              8'h0D: begin
                col_next = 7'd0;
                lin_next = lin - ADDR_W'(cur_col);
              end
              8'h08: begin
                if (cur_col != 7'd0) begin
                  col_next   = cur_col - 7'd1;
                  lin_next   = lin - ADDR_W'(1);
                  wea_next   = 1'b1;
                  addra_next = lin - ADDR_W'(1);
                  dia_next   = 8'h20;
                end else begin
                  col_next = cur_col;
                end
              end
              default: begin
                col_next = cur_col;
              end
            endcase
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        wea_next   = 1'b1;
        addra_next = cnt;
        dia_next   = 8'h20;
        if (cnt == LAST_ADDR) begin
          state_next = S_IDLE;
        end else begin
          busy_next = 1'b1;
          cnt_next  = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cur_col <= 7'd0;
      cur_row <= 7'd0;
      lin     <= ZERO_ADDR;
      cnt     <= ZERO_ADDR;
      wea     <= 1'b0;
      addra   <= ZERO_ADDR;
      dia     <= 8'h00;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cur_col <= col_next;
      cur_row <= row_next;
      lin     <= lin_next;
      cnt     <= cnt_next;
      wea     <= wea_next;
      addra   <= addra_next;
      dia     <= dia_next;
      busy    <= busy_next;
    end
  end

endmodule
